// File: rtl/convenc_subblock_reader.sv
// convenc_subblock_reader
//
// Drains the three encoder subblock buffers (q0, q1, q2) and emits them as a
// single interleaved byte stream per code block: q0[i], q1[i], q2[i], then i+1.
// Each byte takes a REQ -> CAPT -> HOLD round trip. REQ pulses the read
// strobe, CAPT registers the returned byte, and HOLD presents it until it is
// accepted.
//
// Ports:
//   clk, reset          sole rising-edge clock, synchronous active-high reset
//   computation_done    one-cycle pulse: a full block sits in all subblocks
//   blk_meta[7:0]       bit 0 selects block size (0 small, 1 large)
//   q0, q1, q2          subblock read data, valid the cycle after the strobe
//   rdreq_subblock[2:0] one-hot read strobe, bit n reads subblock n
//   out_data[7:0]       output byte
//   out_stream[1:0]     source subblock of out_data
//   out_valid/out_ready valid/ready handshake for the output byte
//   out_sop, out_eop    first / last byte of the block
//   busy                block in progress (start until last byte accepted)
//   overrun             sticky: a block arrived while one was already pending
//   byte_index[9:0]     per-subblock byte index of the current byte

module convenc_subblock_reader #(
  parameter int BYTES_SMALL = 133,
  parameter int BYTES_LARGE = 769
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       computation_done,
  input  logic [7:0] blk_meta,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic [2:0] rdreq_subblock,
  output logic [7:0] out_data,
  output logic [1:0] out_stream,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy,
  output logic       overrun,
  output logic [9:0] byte_index
);

  localparam logic [9:0] N_SMALL = 10'(BYTES_SMALL);
  localparam logic [9:0] N_LARGE = 10'(BYTES_LARGE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPT,
    HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] nBytes_q, nBytes_d;
  logic [9:0] idx_q, idx_d;
  logic [1:0] stream_q, stream_d;
  logic [7:0] outData_q, outData_d;
  logic [1:0] outStream_q, outStream_d;
  logic       outValid_q, outValid_d;
  logic       outSop_q, outSop_d;
  logic       outEop_q, outEop_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       pending_q, pending_d;
  logic       pendMeta_q, pendMeta_d;
  logic [7:0] qSel;

  // Pick the subblock data matching the stream that was just strobed.
  always_comb begin
    case (stream_q)
      2'd0:    qSel = q0;
      2'd1:    qSel = q1;
      default: qSel = q2;
    endcase
  end

  // Next-state and output logic. Everything holds by default, so a stalled
  // HOLD state keeps the presented byte and its markers untouched.
  always_comb begin
    state_d        = state_q;
    nBytes_d       = nBytes_q;
    idx_d          = idx_q;
    stream_d       = stream_q;
    outData_d      = outData_q;
    outStream_d    = outStream_q;
    outValid_d     = outValid_q;
    outSop_d       = outSop_q;
    outEop_d       = outEop_q;
    busy_d         = busy_q;
    overrun_d      = overrun_q;
    pending_d      = pending_q;
    pendMeta_d     = pendMeta_q;
    rdreq_subblock = 3'b000;

    case (state_q)
      IDLE: begin
        if (pending_q || computation_done) begin
          if (pending_q ? pendMeta_q : blk_meta[0]) begin
            nBytes_d = N_LARGE;
          end else begin
            nBytes_d = N_SMALL;
          end
          idx_d    = 10'd0;
          stream_d = 2'd0;
          busy_d   = 1'b1;
          state_d  = REQ;
          // Starting the pending block frees the slot. A pulse arriving on
          // this same cycle then becomes the new pending block.
          if (pending_q) begin
            pending_d = computation_done;
            if (computation_done) begin
              pendMeta_d = blk_meta[0];
            end
          end
        end
      end

      REQ: begin
        rdreq_subblock = 3'b001 << stream_q;
        state_d        = CAPT;
      end

      CAPT: begin
        outData_d   = qSel;
        outStream_d = stream_q;
        outValid_d  = 1'b1;
        outSop_d    = (idx_q == 10'd0) && (stream_q == 2'd0);
        outEop_d    = (idx_q == nBytes_q - 10'd1) && (stream_q == 2'd2);
        state_d     = HOLD;
      end

      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          outSop_d   = 1'b0;
          outEop_d   = 1'b0;
          if (outEop_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if (stream_q == 2'd2) begin
              stream_d = 2'd0;
              idx_d    = idx_q + 10'd1;
            end else begin
              stream_d = stream_q + 2'd1;
            end
            state_d = REQ;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A block announced while one is running waits in the single pending
    // slot. If that slot is taken, the block is dropped and overrun sticks.
    if ((state_q != IDLE) && computation_done) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d  = 1'b1;
        pendMeta_d = blk_meta[0];
      end
    end
  end

  // State register. Reset abandons any block in flight on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      nBytes_q    <= N_SMALL;
      idx_q       <= 10'd0;
      stream_q    <= 2'd0;
      outData_q   <= 8'd0;
      outStream_q <= 2'd0;
      outValid_q  <= 1'b0;
      outSop_q    <= 1'b0;
      outEop_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
      pendMeta_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nBytes_q    <= nBytes_d;
      idx_q       <= idx_d;
      stream_q    <= stream_d;
      outData_q   <= outData_d;
      outStream_q <= outStream_d;
      outValid_q  <= outValid_d;
      outSop_q    <= outSop_d;
      outEop_q    <= outEop_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
      pendMeta_q  <= pendMeta_d;
    end
  end

  assign out_data   = outData_q;
  assign out_stream = outStream_q;
  assign out_valid  = outValid_q;
  assign out_sop    = outSop_q;
  assign out_eop    = outEop_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign byte_index = idx_q;

endmodule

// File: tb/tb_convenc_subblock_reader.sv
// tb_convenc_subblock_reader
//
// Testbench for convenc_subblock_reader. An encoder model answers each read
// strobe with a byte derived from the subblock number and that subblock's
// running read count. A per-cycle monitor predicts every accepted byte:
// its data, stream, markers and index. It also checks that stalled payloads
// stay stable. Block-level scenarios come from a table. Pending, overrun,
// coincident-start and mid-block reset are hand-written sequences.

module tb_convenc_subblock_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       computation_done;
  logic [7:0] blk_meta;
  logic [7:0] q0, q1, q2;
  logic [2:0] rdreq_subblock;
  logic [7:0] out_data;
  logic [1:0] out_stream;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic       overrun;
  logic [9:0] byte_index;

  int checks = 0;
  int errors = 0;

  int readCnt[3];
  int acc[3];
  int expQ[$];
  int k = 0;
  int curN = 1;
  int blocksDone = 0;
  int lastIdx = 0;
  int lastBlkBytes = 0;
  int readyMode = 0;
  bit prevStall = 1'b0;
  int prevPayload = 0;
  bit busyCheckNext = 1'b0;

  typedef struct {
    logic [7:0] meta;
    int         mode;
    int         expBytes;
    int         expLastIdx;
  } row_t;

  row_t rows[4];

  always #5 clk = ~clk;

  convenc_subblock_reader #(
    .BYTES_SMALL(133),
    .BYTES_LARGE(769)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .computation_done(computation_done),
    .blk_meta        (blk_meta),
    .q0              (q0),
    .q1              (q1),
    .q2              (q2),
    .rdreq_subblock  (rdreq_subblock),
    .out_data        (out_data),
    .out_stream      (out_stream),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .busy            (busy),
    .overrun         (overrun),
    .byte_index      (byte_index)
  );

  function automatic logic [7:0] dataOf(int s, int c);
    return 8'((c * 37 + s * 101 + 5) % 256);
  endfunction

  // Encoder model: a strobe at an edge returns the next byte of that subblock
  // on the following cycle.
  always @(posedge clk) begin
    if (reset) begin
      readCnt <= '{default: 0};
      q0 <= 8'd0;
      q1 <= 8'd0;
      q2 <= 8'd0;
    end else begin
      if (rdreq_subblock[0]) begin
        q0 <= dataOf(0, readCnt[0]);
        readCnt[0] <= readCnt[0] + 1;
      end
      if (rdreq_subblock[1]) begin
        q1 <= dataOf(1, readCnt[1]);
        readCnt[1] <= readCnt[1] + 1;
      end
      if (rdreq_subblock[2]) begin
        q2 <= dataOf(2, readCnt[2]);
        readCnt[2] <= readCnt[2] + 1;
      end
    end
  end

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic int payload();
    return int'({out_valid, out_data, out_stream, out_sop, out_eop, byte_index});
  endfunction

  // Advance to the next falling edge, check the outputs there, choose
  // out_ready for the coming edge, and score the byte if it will be accepted.
  task automatic tick();
    logic [7:0] expData;
    int s;
    int idx;
    @(negedge clk);
    if (busyCheckNext) begin
      checkOutput("busyFall", int'(busy), 0);
      busyCheckNext = 1'b0;
    end
    if (prevStall) begin
      checkOutput("stallStable", payload(), prevPayload);
    end
    if (rdreq_subblock != 3'b000) begin
      checkOutput("rdreqOneHot", $countones(rdreq_subblock), 1);
    end
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (out_valid && out_ready) begin
      if (k == 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBlock", 1, 0);
          curN = 1;
        end else begin
          curN = expQ.pop_front();
        end
      end
      s = k % 3;
      idx = k / 3;
      expData = dataOf(s, acc[s]);
      checkOutput("byte", int'({out_data, out_stream, out_sop, out_eop, byte_index}),
                  int'({expData, 2'(s), (k == 0), (k == 3 * curN - 1), 10'(idx)}));
      acc[s]++;
      if (k == 3 * curN - 1) begin
        checkOutput("busyAtEop", int'(busy), 1);
        blocksDone++;
        lastIdx = int'(byte_index);
        lastBlkBytes = k + 1;
        k = 0;
        busyCheckNext = 1'b1;
      end else begin
        k++;
      end
    end
    prevStall = out_valid && !out_ready;
    prevPayload = payload();
  endtask

  task automatic pulseDone(logic [7:0] meta);
    computation_done = 1'b1;
    blk_meta = meta;
    tick();
    computation_done = 1'b0;
    blk_meta = 8'h00;
  endtask

  task automatic runBlocks(int target, int budget);
    int n = 0;
    while ((blocksDone < target || busy || busyCheckNext) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("blocksDone", blocksDone, target);
  endtask

  // One table row: start a block, check first-byte latency, drain it, then
  // check its length, final index and per-subblock read count.
  task automatic applyStimulus(row_t r);
    int n;
    int r0;
    int r1;
    int r2;
    n = r.meta[0] ? 769 : 133;
    readyMode = r.mode;
    r0 = readCnt[0];
    r1 = readCnt[1];
    r2 = readCnt[2];
    expQ.push_back(n);
    pulseDone(r.meta);
    checkOutput("firstRdreq", int'(rdreq_subblock), 1);
    tick();
    checkOutput("captNoValid", int'(out_valid), 0);
    tick();
    checkOutput("firstValid", int'(out_valid), 1);
    runBlocks(blocksDone + 1, 12 * n + 100);
    checkOutput("blockBytes", lastBlkBytes, r.expBytes);
    checkOutput("lastIndex", lastIdx, r.expLastIdx);
    checkOutput("reads0", readCnt[0] - r0, n);
    checkOutput("reads1", readCnt[1] - r1, n);
    checkOutput("reads2", readCnt[2] - r2, n);
    checkOutput("noOverrun", int'(overrun), 0);
  endtask

  initial begin
    int n;
    int sawBusy;

    rows[0] = '{meta: 8'h00, mode: 0, expBytes: 399,  expLastIdx: 132};
    rows[1] = '{meta: 8'h01, mode: 0, expBytes: 2307, expLastIdx: 768};
    rows[2] = '{meta: 8'h00, mode: 1, expBytes: 399,  expLastIdx: 132};
    rows[3] = '{meta: 8'hFE, mode: 1, expBytes: 399,  expLastIdx: 132};

    acc = '{default: 0};
    reset = 1'b1;
    computation_done = 1'b0;
    blk_meta = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetOutputs",
                int'({rdreq_subblock, out_data, out_stream, out_valid, out_sop,
                      out_eop, busy, overrun, byte_index}), 0);
    reset = 1'b0;
    tick();

    $display("[TB] table-driven blocks");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rows[i]);
    end

    $display("[TB] computation_done coincident with final accept");
    readyMode = 0;
    expQ.push_back(133);
    expQ.push_back(133);
    pulseDone(8'h00);
    n = 0;
    while (!(out_valid && out_eop && out_ready) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("eopReached", int'(out_valid && out_eop && out_ready), 1);
    computation_done = 1'b1;
    blk_meta = 8'h00;
    tick();
    computation_done = 1'b0;
    checkOutput("coincIdleRdreq", int'({busy, rdreq_subblock}), 0);
    tick();
    checkOutput("coincRdreq", int'(rdreq_subblock), 1);
    runBlocks(blocksDone + 1, 2000);
    checkOutput("coincNoOverrun", int'(overrun), 0);

    $display("[TB] pending block and overrun");
    expQ.push_back(133);
    expQ.push_back(769);
    pulseDone(8'h00);
    repeat (20) tick();
    pulseDone(8'h01);
    checkOutput("pendNoOverrun", int'(overrun), 0);
    repeat (10) tick();
    pulseDone(8'h00);
    checkOutput("overrunSet", int'(overrun), 1);
    runBlocks(blocksDone + 2, 12000);
    checkOutput("secondIsLarge", lastIdx, 768);
    sawBusy = 0;
    repeat (30) begin
      tick();
      if (busy || rdreq_subblock != 3'b000) sawBusy = 1;
    end
    checkOutput("noThirdBlock", sawBusy, 0);
    checkOutput("overrunSticky", int'(overrun), 1);

    $display("[TB] reset in the middle of a large block");
    expQ.push_back(769);
    pulseDone(8'h01);
    n = 0;
    while (k < 50 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("reachedByte50", int'(k >= 50), 1);
    reset = 1'b1;
    readyMode = 2;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midResetOutputs",
                int'({rdreq_subblock, out_data, out_stream, out_valid, out_sop,
                      out_eop, busy, overrun, byte_index}), 0);
    k = 0;
    expQ.delete();
    acc = '{default: 0};
    prevStall = 1'b0;
    busyCheckNext = 1'b0;
    readyMode = 0;
    tick();
    checkOutput("postResetIdle", int'({busy, rdreq_subblock}), 0);
    expQ.push_back(133);
    pulseDone(8'h00);
    checkOutput("restartRdreq", int'(rdreq_subblock), 1);
    runBlocks(blocksDone + 1, 2000);
    checkOutput("restartLastIdx", lastIdx, 132);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
